// File: rtl/div_issue_ctrl_if.sv
// Request/response handshake bundle between the execute stage and div_issue_ctrl.
// master = execute stage (issues requests, consumes results); slave = controller.
interface div_issue_ctrl_if #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 5
);
    logic             req_valid;
    logic             req_ready;
    logic [1:0]       req_op;
    logic [XLEN-1:0]  req_dividend;
    logic [XLEN-1:0]  req_divisor;
    logic [TAG_W-1:0] req_tag;

    logic             rsp_valid;
    logic             rsp_ready;
    logic [XLEN-1:0]  rsp_result;
    logic [TAG_W-1:0] rsp_tag;

    modport master (
        output req_valid, req_op, req_dividend, req_divisor, req_tag, rsp_ready,
        input  req_ready, rsp_valid, rsp_result, rsp_tag
    );

    modport slave (
        input  req_valid, req_op, req_dividend, req_divisor, req_tag, rsp_ready,
        output req_ready, rsp_valid, rsp_result, rsp_tag
    );
endinterface

// File: rtl/div_issue_ctrl.sv
// Issue controller for the shared multi-cycle divider: resolves RISC-V special cases
// locally, replays the last divider result from a one-entry cache, and handles flush/drain.
module div_issue_ctrl #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 5
) (
    input  logic            CLK,
    input  logic            rst,
    input  logic            flush,
    div_issue_ctrl_if.slave bus,
    output logic            busy,
    output logic            div_data_valid,
    output logic [1:0]      div_operation,
    output logic [XLEN-1:0] div_dividend,
    output logic [XLEN-1:0] div_divisor,
    input  logic [XLEN-1:0] div_product,
    input  logic            div_data_ready
);
    localparam logic [XLEN-1:0] INT_MIN  = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [XLEN-1:0] ALL_ONES = {XLEN{1'b1}};

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LAUNCH = 3'd1,
        WAIT   = 3'd2,
        RESP   = 3'd3,
        DRAIN  = 3'd4
    } state_t;

    state_t state_reg, state_next;

    logic [1:0]       op_reg;
    logic [XLEN-1:0]  dividend_reg;
    logic [XLEN-1:0]  divisor_reg;
    logic [TAG_W-1:0] tag_reg;
    logic [XLEN-1:0]  result_reg;

    logic             cache_valid_reg;
    logic [1:0]       cache_op_reg;
    logic [XLEN-1:0]  cache_dividend_reg;
    logic [XLEN-1:0]  cache_divisor_reg;
    logic [XLEN-1:0]  cache_result_reg;

    logic             busy_reg;
    logic             rsp_valid_reg;
    logic             div_data_valid_reg;

    logic             accept;
    logic             div_by_zero;
    logic             signed_ovf;
    logic             cache_hit;
    logic             fast_path;
    logic [XLEN-1:0]  fast_result;
    logic             div_done;

    // req_ready is held low while reset is asserted so every output reads 0 in reset.
    assign bus.req_ready  = (state_reg == IDLE) & ~flush & ~rst;
    assign accept         = bus.req_valid & bus.req_ready;
    assign div_done       = (state_reg == WAIT) & div_data_ready & ~flush;

    assign bus.rsp_valid  = rsp_valid_reg;
    assign bus.rsp_result = result_reg;
    assign bus.rsp_tag    = tag_reg;
    assign busy           = busy_reg;
    assign div_data_valid = div_data_valid_reg;
    assign div_operation  = op_reg;
    assign div_dividend   = dividend_reg;
    assign div_divisor    = divisor_reg;

    // op[0]=1 selects unsigned, op[1]=1 selects remainder.
    always_comb begin
        div_by_zero = (bus.req_divisor == '0);
        signed_ovf  = ~bus.req_op[0] & (bus.req_dividend == INT_MIN) & (bus.req_divisor == ALL_ONES);
        cache_hit   = cache_valid_reg
                    & (bus.req_op       == cache_op_reg)
                    & (bus.req_dividend == cache_dividend_reg)
                    & (bus.req_divisor  == cache_divisor_reg);
        fast_path   = div_by_zero | signed_ovf | cache_hit;
        fast_result = cache_result_reg;
        if (div_by_zero) begin
            fast_result = bus.req_op[1] ? bus.req_dividend : ALL_ONES;
        end else if (signed_ovf) begin
            fast_result = bus.req_op[1] ? '0 : bus.req_dividend;
        end
    end

    // Flush outranks every other transition; a launched divide cannot be aborted and is drained.
    always_comb begin
        state_next = state_reg;
        unique case (state_reg)
            IDLE: begin
                if (accept) begin
                    state_next = fast_path ? RESP : LAUNCH;
                end
            end
            LAUNCH: state_next = flush ? DRAIN : WAIT;
            WAIT: begin
                if (flush) begin
                    state_next = div_data_ready ? IDLE : DRAIN;
                end else if (div_data_ready) begin
                    state_next = RESP;
                end
            end
            RESP: begin
                if (flush || bus.rsp_ready) begin
                    state_next = IDLE;
                end
            end
            DRAIN: begin
                if (div_data_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge rst) begin
        if (rst) begin
            state_reg          <= IDLE;
            busy_reg           <= 1'b0;
            rsp_valid_reg      <= 1'b0;
            div_data_valid_reg <= 1'b0;
            op_reg             <= '0;
            dividend_reg       <= '0;
            divisor_reg        <= '0;
            tag_reg            <= '0;
            result_reg         <= '0;
            cache_valid_reg    <= 1'b0;
            cache_op_reg       <= '0;
            cache_dividend_reg <= '0;
            cache_divisor_reg  <= '0;
            cache_result_reg   <= '0;
        end else begin
            state_reg          <= state_next;
            busy_reg           <= (state_next != IDLE);
            rsp_valid_reg      <= (state_next == RESP);
            div_data_valid_reg <= (state_next == LAUNCH);

            if (accept) begin
                op_reg       <= bus.req_op;
                dividend_reg <= bus.req_dividend;
                divisor_reg  <= bus.req_divisor;
                tag_reg      <= bus.req_tag;
                if (fast_path) begin
                    result_reg <= fast_result;
                end
            end

            // Only a divide that completes unflushed may populate the cache.
            if (div_done) begin
                result_reg         <= div_product;
                cache_valid_reg    <= 1'b1;
                cache_op_reg       <= op_reg;
                cache_dividend_reg <= dividend_reg;
                cache_divisor_reg  <= divisor_reg;
                cache_result_reg   <= div_product;
            end
        end
    end
endmodule
